// File: rtl/semis_sar_pkg.sv
`default_nettype none
// ============================================================================
// semis_sar_pkg : shared state encoding and defaults for the SAR controller
// Rev 1.0
// ============================================================================
package semis_sar_pkg;

    localparam int DEF_N_BITS        = 8;
    localparam int DEF_SAMPLE_CYCLES = 2;
    localparam int DEF_SETTLE_CYCLES = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_SETTLE = 3'd2,
        S_DECIDE = 3'd3,
        S_DONE   = 3'd4
    } sar_state_t;

    // One counter serves both timed phases; it only ever reaches max-1.
    function automatic int sar_cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/semis_sync2.sv
`default_nettype none
// ============================================================================
// semis_sync2 : two-flop synchronizer, synchronous active-low reset to 0
// Rev 1.0
// ============================================================================
module semis_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/semis_sar_ctrl.sv
`default_nettype none
// ============================================================================
// semis_sar_ctrl : successive-approximation ADC controller (track, per-bit
//                  settle/decide, single-cycle done pulse)
// Rev 1.0
// ============================================================================
module semis_sar_ctrl
    import semis_sar_pkg::*;
#(
    parameter int N_BITS        = DEF_N_BITS,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmp_in,
    output logic              sample,
    output logic [N_BITS-1:0] dac_code,
    output logic [N_BITS-1:0] result,
    output logic              busy,
    output logic              done
);

    localparam int c_cnt_w = sar_cnt_width(SAMPLE_CYCLES, SETTLE_CYCLES);
    localparam int c_idx_w = $clog2(N_BITS);

    localparam logic [c_cnt_w-1:0] c_sample_last = c_cnt_w'(SAMPLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_top     = c_idx_w'(N_BITS - 1);
    localparam logic [c_idx_w-1:0] c_idx_one     = c_idx_w'(1);
    localparam logic [N_BITS-1:0]  c_code_one    = N_BITS'(1);
    localparam logic [N_BITS-1:0]  c_code_msb    = c_code_one << (N_BITS - 1);

    sar_state_t          r_state;
    sar_state_t          w_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [N_BITS-1:0]   r_dac;
    logic [N_BITS-1:0]   r_result;
    logic [N_BITS-1:0]   w_bit;
    logic [N_BITS-1:0]   w_kept;
    logic                w_cmp_s;

    semis_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (cmp_in),
        .o_q   (w_cmp_s)
    );

    // Bit under trial and the code with that bit resolved by the comparator.
    assign w_bit  = c_code_one << r_idx;
    assign w_kept = w_cmp_s ? r_dac : (r_dac & ~w_bit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        sample = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                sample = 1'b1;
                busy   = 1'b1;
                if (r_cnt == c_sample_last) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (r_cnt == c_settle_last) begin
                    w_next = S_DECIDE;
                end
            end
            S_DECIDE: begin
                busy   = 1'b1;
                w_next = (r_idx == '0) ? S_DONE : S_SETTLE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_dac    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_dac <= '0;
                end
                S_SAMPLE: begin
                    if (r_cnt == c_sample_last) begin
                        r_cnt <= '0;
                        r_idx <= c_idx_top;
                        r_dac <= c_code_msb;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == c_settle_last) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_DECIDE: begin
                    if (r_idx != '0) begin
                        r_dac <= w_kept | (w_bit >> 1);
                        r_idx <= r_idx - c_idx_one;
                    end else begin
                        r_dac    <= w_kept;
                        r_result <= w_kept;
                    end
                end
                S_DONE: begin
                    // Final code stays on the DAC for the DONE cycle only.
                    r_dac <= '0;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign dac_code = r_dac;
    assign result   = r_result;

endmodule
`default_nettype wire

// File: tb/tb_semis_sar_ctrl.sv
`default_nettype none
// ============================================================================
// tb_semis_sar_ctrl : directed and randomized checks of semis_sar_ctrl
// Rev 1.0
// ============================================================================
module tb_semis_sar_ctrl;

    localparam int N       = 8;
    localparam int SAMP    = 2;
    localparam int SETL    = 3;
    localparam int LAT     = 1 + SAMP + N * (SETL + 1);
    localparam int LOG_LEN = 128;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         cmp_in;
    logic         sample;
    logic [N-1:0] dac_code;
    logic [N-1:0] result;
    logic         busy;
    logic         done;

    logic [N-1:0] vin    = '0;
    logic         noisy  = 1'b0;
    logic         glitch = 1'b0;
    logic         cmp_ideal;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic         done_log [LOG_LEN];
    logic         busy_log [LOG_LEN];
    logic         samp_log [LOG_LEN];
    logic [N-1:0] dac_log  [LOG_LEN];
    logic [N-1:0] res_log  [LOG_LEN];

    semis_sar_ctrl #(
        .N_BITS        (N),
        .SAMPLE_CYCLES (SAMP),
        .SETTLE_CYCLES (SETL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cmp_in   (cmp_in),
        .sample   (sample),
        .dac_code (dac_code),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Analog input sits half an LSB above code vin, so the ideal SAR lands on vin.
    assign cmp_ideal = ({vin, 1'b1} > {dac_code, 1'b0});
    assign cmp_in    = cmp_ideal ^ glitch;

    // Comparator chatter right after each DAC step, gone well before it is used.
    always @(dac_code) begin
        if (noisy) begin
            for (int g = 0; g < 4; g++) begin
                #($urandom_range(1, 3));
                glitch = 1'($urandom_range(0, 1));
            end
            glitch = 1'b0;
        end
    end

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (cyc < LOG_LEN) begin
            done_log[cyc] = done;
            busy_log[cyc] = busy;
            samp_log[cyc] = sample;
            dac_log[cyc]  = dac_code;
            res_log[cyc]  = result;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input logic [N-1:0] v0, input logic [N-1:0] v1,
                       input int pa, input int pb, input int rst_at,
                       input bit hold, input int len);
        cyc = 0;
        for (int c = 0; c < len; c++) begin
            start = (c == 0) || (c == pa) || (c == pb) || (hold && c <= LAT + 1);
            rst_n = (c != rst_at);
            vin   = (c > LAT) ? v1 : v0;
            step();
        end
        start = 1'b0;
        rst_n = 1'b1;
    endtask

    // Binary-search trial k: bits above the trial bit equal vin, trial bit set.
    function automatic logic [N-1:0] trial(input logic [N-1:0] v, input int k);
        int b;
        int keep;
        b    = N - 1 - k;
        keep = (int'(v) >> (b + 1)) << (b + 1);
        return N'(keep | (1 << b));
    endfunction

    task automatic check_conv(input string tag, input logic [N-1:0] v,
                              input logic [N-1:0] prev, input int at);
        int           s0;
        int           ndone;
        int           nsamp;
        int           ntr;
        logic [N-1:0] tr [N];
        s0    = at - LAT;
        ndone = 0;
        nsamp = 0;
        ntr   = 0;
        for (int k = 0; k < N; k++) tr[k] = '0;
        for (int c = s0; c <= at + 1; c++) begin
            if (done_log[c]) ndone++;
            if (samp_log[c]) nsamp++;
            if (busy_log[c] && !samp_log[c] &&
                (ntr == 0 || dac_log[c] != tr[(ntr - 1) % N])) begin
                if (ntr < N) tr[ntr] = dac_log[c];
                ntr++;
            end
        end
        check(tag, "done_count", ndone, 1);
        check(tag, "done_at_latency", {31'd0, done_log[at]}, 1);
        check(tag, "busy_last_decide", {31'd0, busy_log[at - 1]}, 1);
        check(tag, "busy_in_done", {31'd0, busy_log[at]}, 0);
        check(tag, "sample_cycles", nsamp, SAMP);
        check(tag, "result_before_done", {24'd0, res_log[at - 1]}, {24'd0, prev});
        check(tag, "result", {24'd0, res_log[at]}, {24'd0, v});
        check(tag, "dac_held_in_done", {24'd0, dac_log[at]}, {24'd0, v});
        check(tag, "dac_idle", {24'd0, dac_log[at + 1]}, 0);
        check(tag, "trial_count", ntr, N);
        for (int k = 0; k < N; k++) begin
            check(tag, $sformatf("trial%0d", k), {24'd0, tr[k]}, {24'd0, trial(v, k)});
        end
    endtask

    initial begin
        logic [N-1:0] last_res;
        logic [N-1:0] v;

        // start held high throughout reset must not launch a conversion
        rst_n = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("reset", "busy", {31'd0, busy}, 0);
        check("reset", "sample", {31'd0, sample}, 0);
        check("reset", "done", {31'd0, done}, 0);
        check("reset", "dac_code", {24'd0, dac_code}, 0);
        check("reset", "result", {24'd0, result}, 0);
        @(posedge clk);
        #1;
        last_res = '0;

        run(8'hA5, 8'hA5, -1, -1, -1, 1'b0, LAT + 4);
        check_conv("vin_a5", 8'hA5, last_res, LAT);
        last_res = 8'hA5;

        run(8'hFF, 8'hFF, -1, -1, -1, 1'b0, LAT + 4);
        check_conv("vin_ff", 8'hFF, last_res, LAT);
        last_res = 8'hFF;

        run(8'h00, 8'h00, -1, -1, -1, 1'b0, LAT + 4);
        check_conv("vin_00", 8'h00, last_res, LAT);
        last_res = 8'h00;

        v = N'($urandom);
        run(v, v, 5, 20, -1, 1'b0, LAT + 4);
        check_conv("repulse", v, last_res, LAT);
        last_res = v;

        // Synchronous reset sampled at the end of cycle 10
        v = N'($urandom_range(1, 255));
        run(v, v, -1, -1, 10, 1'b0, LAT + 4);
        check("midreset", "busy", {31'd0, busy_log[11]}, 0);
        check("midreset", "sample", {31'd0, samp_log[11]}, 0);
        check("midreset", "dac_code", {24'd0, dac_log[11]}, 0);
        check("midreset", "result", {24'd0, res_log[LAT + 2]}, 0);
        begin
            int nd;
            nd = 0;
            for (int c = 0; c < LAT + 4; c++) if (done_log[c]) nd++;
            check("midreset", "done_count", nd, 0);
        end
        last_res = '0;
        v = N'($urandom);
        run(v, v, -1, -1, -1, 1'b0, LAT + 4);
        check_conv("after_reset", v, last_res, LAT);
        last_res = v;

        run(8'h3C, 8'hC3, -1, -1, -1, 1'b1, 2 * LAT + 4);
        check_conv("hold1", 8'h3C, last_res, LAT);
        check_conv("hold2", 8'hC3, 8'h3C, 2 * LAT + 1);
        check("hold", "idle_gap_busy", {31'd0, busy_log[LAT + 1]}, 0);
        check("hold", "restart_sample", {31'd0, samp_log[LAT + 2]}, 1);
        last_res = 8'hC3;

        for (int i = 0; i < 6; i++) begin
            noisy = (i % 2 == 0);
            v     = N'($urandom);
            run(v, v, -1, -1, -1, 1'b0, LAT + 4);
            check_conv($sformatf("rand%0d", i), v, last_res, LAT);
            last_res = v;
        end
        noisy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
